// File: rtl/sw_quad_fetch.sv
// Raster quad fetcher: walks a QW x QH window of 2x2 quads from an origin, reads
// memory port A and streams quads out through a 2-entry buffer. Optional macro SW_QUAD_FETCH_WRAP_EN.
module sw_quad_fetch #(
  parameter int QW = 8,
  parameter int QH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  qx0,
  input  logic [4:0]  qy0,
  output logic        busy,
  output logic [9:0]  addr_a,
  input  logic [31:0] q_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_quad,
  output logic [4:0]  out_qx,
  output logic [4:0]  out_qy,
  output logic        out_last,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [4:0] qx;
    logic [4:0] qy;
    logic       last;
  } tag_t;
  typedef struct packed {
    logic [31:0] quad;
    tag_t        tag;
  } ent_t;

  localparam logic [4:0] XL = 5'(QW - 1);
  localparam logic [4:0] YL = 5'(QH - 1);

  state_t     state, state_nx;
  logic [4:0] ox0, oy0;
  logic [4:0] nx, ny;
  logic       if_vld;
  tag_t       if_tag;
  ent_t       head, skid, inc;
  logic       skid_vld;
  logic       range_ok, start_ok, pop, credit_ok, issue, iss_last;
  logic [4:0] iss_x, iss_y, bx, by;
  logic [2:0] occ;

`ifdef SW_QUAD_FETCH_WRAP_EN
  assign range_ok = 1'b1;
`else
  assign range_ok = (({1'b0, qx0} + 6'(QW)) <= 6'd32) &&
                    (({1'b0, qy0} + 6'(QH)) <= 6'd32);
`endif

  assign start_ok  = (state == IDLE) && start && range_ok;
  assign pop       = out_valid && out_ready;
  assign occ       = 3'(out_valid) + 3'(skid_vld);
  // Keep buffered + in-flight entries within the two buffer slots after this edge.
  assign credit_ok = (occ + 3'(if_vld)) <= (3'd1 + 3'(pop));
  assign issue     = start_ok || ((state == RUN) && credit_ok);
  assign iss_x     = (state == IDLE) ? 5'd0 : nx;
  assign iss_y     = (state == IDLE) ? 5'd0 : ny;
  assign bx        = (state == IDLE) ? qx0 : ox0;
  assign by        = (state == IDLE) ? qy0 : oy0;
  assign iss_last  = (iss_x == XL) && (iss_y == YL);
  assign inc       = '{quad: q_a, tag: if_tag};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = iss_last ? DRAIN : RUN;
      RUN:     if (issue && iss_last) state_nx = DRAIN;
      DRAIN:   if (pop && head.tag.last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = pop && head.tag.last;
    out_quad = head.quad;
    out_qx   = head.tag.qx;
    out_qy   = head.tag.qy;
    out_last = out_valid && head.tag.last;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ox0       <= '0;
      oy0       <= '0;
      nx        <= '0;
      ny        <= '0;
      addr_a    <= '0;
      if_vld    <= 1'b0;
      if_tag    <= '0;
      head      <= '0;
      skid      <= '0;
      skid_vld  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (start_ok) begin
        ox0 <= qx0;
        oy0 <= qy0;
      end
      if (issue) begin
        // 5-bit sums: coordinates wrap modulo 32 when range checking is off.
        addr_a <= {by + iss_y, bx + iss_x};
        if_tag <= '{qx: iss_x, qy: iss_y, last: iss_last};
        nx     <= (iss_x == XL) ? 5'd0 : iss_x + 5'd1;
        ny     <= (iss_x == XL) ? iss_y + 5'd1 : iss_y;
      end
      if_vld <= issue;
      if (pop) begin
        if (skid_vld) begin
          head     <= skid;
          skid_vld <= if_vld;
          if (if_vld) skid <= inc;
        end else begin
          out_valid <= if_vld;
          if (if_vld) head <= inc;
        end
      end else if (if_vld) begin
        if (!out_valid) begin
          head      <= inc;
          out_valid <= 1'b1;
        end else begin
          skid     <= inc;
          skid_vld <= 1'b1;
        end
      end
    end
  end

`ifdef SW_QUAD_FETCH_WRAP_EN
  assign err = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (!rst_n)                      err <= 1'b0;
    else if (state == IDLE && start) err <= !range_ok;
  end
`endif

endmodule

// File: tb/tb_sw_quad_fetch.sv
// Randomized bench for sw_quad_fetch: a queue model of the raster scan is checked
// against the output stream every cycle, plus directed pins of addresses and timing.
module tb_sw_quad_fetch;
  localparam int QW = 8;
  localparam int QH = 8;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [4:0]  qx0 = '0, qy0 = '0;
  logic        busy, out_valid, out_last, done, err;
  logic [9:0]  addr_a;
  logic [31:0] q_a, out_quad;
  logic [4:0]  out_qx, out_qy;
  logic [31:0] mem [1024];

  typedef struct packed {
    logic [31:0] quad;
    logic [4:0]  qx;
    logic [4:0]  qy;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_chk = 0, n_fail = 0, n_xfer = 0, done_cnt = 0, addr_chg = 0;
  int          cyc = 0, done_cyc = 0;
  bit          stall_prev = 0;
  logic [42:0] prev_vec = '0;
  logic [9:0]  prev_addr = '0;

  sw_quad_fetch #(.QW(QW), .QH(QH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .qx0(qx0), .qy0(qy0),
    .busy(busy), .addr_a(addr_a), .q_a(q_a), .out_valid(out_valid),
    .out_ready(out_ready), .out_quad(out_quad), .out_qx(out_qx), .out_qy(out_qy),
    .out_last(out_last), .done(done), .err(err)
  );

  assign q_a = mem[addr_a];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference scan: raster offsets, coordinates are origin + offset modulo 32.
  function automatic void push_scan(input logic [4:0] x0, input logic [4:0] y0);
    for (int y = 0; y < QH; y++) begin
      for (int x = 0; x < QW; x++) begin
        logic [4:0] ax, ay;
        exp_t e;
        ax = x0 + 5'(x);
        ay = y0 + 5'(y);
        e.quad = mem[{ay, ax}];
        e.qx   = 5'(x);
        e.qy   = 5'(y);
        e.last = (x == QW - 1) && (y == QH - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev)
        chk("stall_stable", {out_valid, out_quad, out_qx, out_qy, out_last}, {1'b1, prev_vec});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_quad: got quad 0x%0h at (%0d,%0d) expected none", out_quad, out_qx, out_qy);
        end else begin
          cur = exp_q[0];
          chk("quad", {out_quad, out_qx, out_qy, out_last}, cur);
          if (out_ready) begin
            chk("done_on_xfer", done, cur.last);
            void'(exp_q.pop_front());
            n_xfer++;
          end else begin
            chk("done_stall", done, 0);
          end
        end
      end else begin
        chk("done_quiet", done, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      prev_vec   = {out_quad, out_qx, out_qy, out_last};
      if (addr_a != prev_addr) addr_chg++;
      prev_addr = addr_a;
    end
  end

  task automatic start_scan(input logic [4:0] x0, input logic [4:0] y0);
    push_scan(x0, y0);
    qx0 = x0;
    qy0 = y0;
    addr_chg = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // rmode: 0 ready high, 1 toggle 1/0, 2 random 50%, 3 random 25%; 2/3 also poke start while busy.
  task automatic finish_scan(input int rmode);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 2 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ($urandom_range(0, 3) == 0);
      endcase
      if (rmode >= 2 && busy) begin
        start = 1'($urandom_range(0, 1));
        qx0   = 5'($urandom);
        qy0   = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL scan_timeout: got no done, expected done within 3000 cycles");
    end else begin
      chk("busy_after_done", busy, 0);
    end
    chk("queue_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    int n0, d0, t0;
    logic [9:0] a_prev;
    bit ok;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, addr_a, out_valid, out_quad, out_qx, out_qy, out_last, done, err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed full-rate scan from (3,2).
    out_ready = 1'b1;
    n0 = n_xfer;
    start_scan(5'd3, 5'd2);
    chk("first_addr", addr_a, 10'h043);
    chk("no_early_valid", out_valid, 0);
    t0 = cyc;
    finish_scan(0);
    chk("done_cycle_offset", 64'(done_cyc - (t0 - 1)), 65);
    chk("last_addr_hold", addr_a, 10'h12A);
    chk("xfer_count_full", 64'(n_xfer - n0), 64);

    // Same scan with ready toggling.
    n0 = n_xfer;
    start_scan(5'd3, 5'd2);
    finish_scan(1);
    chk("xfer_count_toggle", 64'(n_xfer - n0), 64);

    // Consumer stalled for 10 cycles after start.
    out_ready = 1'b0;
    start_scan(5'd3, 5'd2);
    repeat (9) begin @(posedge clk); #1; end
    chk("stall_addr_hold", addr_a, 10'h044);
    chk("stall_reads_issued", 64'(addr_chg), 2);
    chk("stall_head_valid", out_valid, 1);
    chk("stall_head_quad", out_quad, mem[10'h043]);
    finish_scan(0);

`ifdef SW_QUAD_FETCH_WRAP_EN
    out_ready = 1'b1;
    start_scan(5'd30, 5'd0);
    chk("wrap_addr0", addr_a, 10'h01E);
    @(posedge clk); #1;
    chk("wrap_addr1", addr_a, 10'h01F);
    @(posedge clk); #1;
    chk("wrap_addr2", addr_a, 10'h000);
    @(posedge clk); #1;
    chk("wrap_addr3", addr_a, 10'h001);
    finish_scan(0);
    start_scan(5'd29, 5'd27);
    chk("wrap_err_low", err, 0);
    finish_scan(2);
`else
    a_prev = addr_a;
    qx0 = 5'd30; qy0 = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("range_err_x", err, 1);
    chk("range_busy_low", busy, 0);
    chk("range_addr_hold", addr_a, a_prev);
    qx0 = 5'd0; qy0 = 5'd25; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("range_err_y", err, 1);
    repeat (4) begin @(posedge clk); #1; end
    chk("range_no_valid", out_valid, 0);
    chk("range_still_idle", busy, 0);
    start_scan(5'd0, 5'd0);
    chk("range_err_cleared", err, 0);
    finish_scan(3);
`endif

    // Window touching the far corner exactly.
    start_scan(5'(32 - QW), 5'(32 - QH));
    chk("corner_busy", busy, 1);
    finish_scan(2);

    for (int r = 0; r < 6; r++) begin
      start_scan(5'($urandom_range(0, 32 - QW)), 5'($urandom_range(0, 32 - QH)));
      finish_scan(r % 4);
    end

    // start held high through done: second identical scan back to back.
    n0 = n_xfer;
    d0 = done_cnt;
    push_scan(5'd5, 5'd7);
    push_scan(5'd5, 5'd7);
    qx0 = 5'd5; qy0 = 5'd7; out_ready = 1'b1; start = 1'b1;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL held_first_done: got no done, expected done within 500 cycles");
    end
    chk("held_busy_low", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_restart_busy", busy, 1);
    chk("held_restart_addr", addr_a, {5'd7, 5'd5});
    finish_scan(0);
    chk("held_xfer_count", 64'(n_xfer - n0), 128);

    // Reset on the 20th transfer, then restart from (0,0).
    n0 = n_xfer;
    d0 = done_cnt;
    out_ready = 1'b1;
    start_scan(5'd3, 5'd2);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (n_xfer - n0 == 19) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL reset_wait: got %0d transfers, expected 19", n_xfer - n0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midscan_reset_outputs", {busy, addr_a, out_valid, out_quad, out_qx, out_qy, out_last, done, err}, 0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_no_done", 64'(done_cnt - d0), 0);
    start_scan(5'd0, 5'd0);
    chk("restart_addr", addr_a, 10'h000);
    finish_scan(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
